// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide datapath: width, op codes, FSM states, special results.
package rv32m_pkg;

  localparam int unsigned XLEN = 32;

  // funct3[1:0] encodings
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Divider FSM state encoding
  typedef logic [1:0] div_state_t;
  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_CALC = 2'd1;
  localparam div_state_t ST_FIX  = 2'd2;
  localparam div_state_t ST_DONE = 2'd3;

  // RISC-V special-case results
  localparam logic [XLEN-1:0] DIV0_Q  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // DIV and REM treat operands as two's complement
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic op_is_rem(input logic [1:0] op);
    return !((op == OP_DIV) || (op == OP_DIVU));
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if #(
  parameter int unsigned XLEN = rv32m_pkg::XLEN
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try to subtract the divisor.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_nxt_c,
  output logic         q_bit_c
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // rem[W] is always zero between iterations, so one extra bit keeps the trial sign unambiguous
  always_comb begin
    shifted   = {rem, dvd_msb};
    trial     = shifted - {2'b00, divisor};
    q_bit_c   = ~trial[W+1];
    rem_nxt_c = q_bit_c ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a one-cycle special-case path.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  div_unit_if.slave bus
);
  import rv32m_pkg::*;

  localparam int unsigned        CNT_W    = 5;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(XLEN - 1);

  div_state_t       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       op_q,     op_d;
  logic             q_neg_q,  q_neg_d;
  logic             r_neg_q,  r_neg_d;
  logic [XLEN-1:0]  dvd_q,    dvd_d;
  logic [XLEN-1:0]  dsr_q,    dsr_d;
  logic [XLEN-1:0]  quo_q,    quo_d;
  logic [XLEN:0]    rem_q,    rem_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN:0]    step_rem_c;
  logic             step_q_c;
  logic             sgn_c;
  logic [XLEN-1:0]  abs1_c, abs2_c;
  logic [XLEN-1:0]  quo_fix_c, rem_fix_c;

  div_step #(.W(XLEN)) u_step (
    .rem       (rem_q),
    .dvd_msb   (dvd_q[XLEN-1]),
    .divisor   (dsr_q),
    .rem_nxt_c (step_rem_c),
    .q_bit_c   (step_q_c)
  );

  // Operand magnitudes at acceptance and sign-corrected results for FIX
  always_comb begin
    sgn_c     = op_is_signed(bus.op_i);
    abs1_c    = (sgn_c && bus.rs1_i[XLEN-1]) ? (~bus.rs1_i + XLEN'(1)) : bus.rs1_i;
    abs2_c    = (sgn_c && bus.rs2_i[XLEN-1]) ? (~bus.rs2_i + XLEN'(1)) : bus.rs2_i;
    quo_fix_c = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    rem_fix_c = r_neg_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          op_d = bus.op_i;
          if (bus.rs2_i == '0) begin
            result_d = op_is_rem(bus.op_i) ? bus.rs1_i : DIV0_Q;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else if (sgn_c && (bus.rs1_i == INT_MIN) && (bus.rs2_i == DIV0_Q)) begin
            result_d = op_is_rem(bus.op_i) ? '0 : INT_MIN;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            dvd_d   = abs1_c;
            dsr_d   = abs2_c;
            q_neg_d = sgn_c & (bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]);
            r_neg_d = sgn_c & bus.rs1_i[XLEN-1];
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = CNT_LAST;
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        rem_d  = step_rem_c;
        quo_d  = {quo_q[XLEN-2:0], step_q_c};
        dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_FIX: begin
        result_d = op_is_rem(op_q) ? rem_fix_c : quo_fix_c;
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random stimulus for div_unit checked against an arithmetic reference model.
module tb_div_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension divide semantics expressed with plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int  sa;
    int  sb;
    logic sgn;
    logic is_rem;
    sgn    = (op == 2'b00) || (op == 2'b10);
    is_rem = op[1];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Issue one operation and check latency, busy span, result and the single valid pulse
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string tag);
    logic [31:0] exp;
    bit          fast;
    bit          held_ok;
    int          lat;
    int          busy_cnt;
    exp  = ref_model(op, a, b);
    fast = (b == 32'd0) || (((op == 2'b00) || (op == 2'b10)) &&
                            a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.op_i  = 2'(op + 2'd1);
      bus.rs1_i = $urandom;
      bus.rs2_i = 32'd0;
    end else begin
      bus.start_i = 1'b0;
    end
    lat      = 0;
    busy_cnt = 0;
    held_ok  = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.valid_o === 1'b1) lat = k;
      else if (bus.result_o !== prev_res) held_ok = 1'b0;
    end
    check({tag, "_lat"},  32'(lat),      fast ? 32'd1 : 32'd34);
    check({tag, "_busy"}, 32'(busy_cnt), fast ? 32'd0 : 32'd33);
    check({tag, "_res"},  bus.result_o,  exp);
    check({tag, "_held"}, 32'(held_ok),  32'd1);
    @(negedge clk);
    check({tag, "_post"}, {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    check({tag, "_keep"}, bus.result_o, exp);
    prev_res = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          vseen;

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    prev_res    = '0;
    repeat (2) @(negedge clk);
    check("rst_out", {bus.valid_o, bus.busy_o, bus.result_o[29:0]}, 32'd0);
    check("rst_res", bus.result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         1'b0, "div_m7_2");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2,         1'b0, "rem_m7_2");
    run_op(OP_DIVU, 32'd100,       32'd7,         1'b0, "divu_100_7");
    run_op(OP_REMU, 32'd100,       32'd7,         1'b0, "remu_100_7");
    run_op(OP_DIVU, 32'd5,         32'd0,         1'b0, "divu_5_0");
    run_op(OP_REM,  32'd5,         32'd0,         1'b0, "rem_5_0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         1'b0, "divu_max_1");
    run_op(OP_DIV,  32'h8000_0000, 32'd2,         1'b0, "div_min_2");

    // start held high through busy and DONE, then an immediate back-to-back op
    run_op(OP_DIVU, 32'd100,       32'd7,         1'b1, "hold");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         1'b0, "b2b");

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2:       r_b = $urandom_range(1, 20);
        3:       r_b = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 1'b0, $sformatf("rnd%0d", i));
    end

    // reset pulse in the middle of a DIVU aborts it without a valid
    run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, "pre_rst");
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIVU;
    bus.rs1_i   = 32'd1000;
    bus.rs2_i   = 32'd3;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    check("rst_mid_res",   bus.result_o, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    prev_res = '0;
    vseen    = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) vseen++;
    end
    check("rst_no_valid", 32'(vseen), 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
